// File: rtl/soc_gpio_pkg.sv
// Shared register map constants for the memory-mapped GPIO peripheral.
// Offsets are byte offsets of 32-bit words inside the 64-byte window.
package soc_gpio_pkg;

    localparam logic [5:0]  GPIO_OUT_OFS  = 6'h00;
    localparam logic [5:0]  GPIO_SET_OFS  = 6'h04;
    localparam logic [5:0]  GPIO_CLR_OFS  = 6'h08;
    localparam logic [5:0]  GPIO_TGL_OFS  = 6'h0C;
    localparam logic [5:0]  GPIO_OE_OFS   = 6'h10;
    localparam logic [5:0]  GPIO_IN_OFS   = 6'h14;
    localparam logic [5:0]  GPIO_EN_OFS   = 6'h18;
    localparam logic [5:0]  GPIO_PEND_OFS = 6'h1C;
    localparam logic [5:0]  GPIO_POL_OFS  = 6'h20;

    localparam logic [31:0] GPIO_WINDOW_BYTES = 32'd64;
    localparam logic [31:0] GPIO_LED_ADDR     = 32'h1200_0000;

endpackage

// File: rtl/gpio_sync.sv
// Input synchroniser chain followed by a prev register for edge detection.
// The prev register and edge outputs exist only when GPIO_IRQ_EN is defined.
module gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign sync_q = chain[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= '0;
        else       prev <= sync_q;
    end

    assign rise = sync_q & ~prev;
    assign fall = ~sync_q & prev;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: decode, register file and read mux on the CPU mem bus.
// Define GPIO_IRQ_EN to build edge-capture interrupts (IRQ_EN/PEND/POL, irq).
module mmio_gpio
    import soc_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = GPIO_LED_ADDR,
    parameter int          WIDTH       = 8,
    parameter logic [31:0] OUT_RESET   = 32'h0000_00F0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [31:0]      addr,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             is_valid,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [31:0]      offset;
    logic [5:0]       ofs;
    logic             accept;
    logic             wr;
    logic [31:0]      strb_mask;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [31:0]      rd_val;

    assign offset   = addr - BASE_ADDR;
    assign is_valid = valid && (addr >= BASE_ADDR) && (offset < GPIO_WINDOW_BYTES);
    assign ofs      = {offset[5:2], 2'b00};
    assign accept   = is_valid && !ready;
    assign wr       = accept && (wstrb != 4'b0000);

    always_comb begin
        strb_mask = '0;
        for (int b = 0; b < 4; b++) strb_mask[8*b +: 8] = {8{wstrb[b]}};
    end

    assign mask  = strb_mask[WIDTH-1:0];
    assign wbits = wdata[WIDTH-1:0] & mask;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (gpio_in),
        .sync_q (sync_q),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= OUT_RESET[WIDTH-1:0];
            oe_q  <= '0;
        end else if (wr) begin
            case (ofs)
                GPIO_OUT_OFS: out_q <= (out_q & ~mask) | wbits;
                GPIO_SET_OFS: out_q <= out_q | wbits;
                GPIO_CLR_OFS: out_q <= out_q & ~wbits;
                GPIO_TGL_OFS: out_q <= out_q ^ wbits;
                GPIO_OE_OFS:  oe_q  <= (oe_q & ~mask) | wbits;
                default: ;
            endcase
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pol;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] pend_clr;

    assign edges    = (pol & fall) | (~pol & rise);
    assign pend_clr = (wr && ofs == GPIO_PEND_OFS) ? wbits : '0;

    // Edge set is ORed in after the W1C so a coincident edge keeps PEND high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= '0;
            pend   <= '0;
            pol    <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | edges;
            if (wr && ofs == GPIO_EN_OFS)  irq_en <= (irq_en & ~mask) | wbits;
            if (wr && ofs == GPIO_POL_OFS) pol    <= (pol & ~mask) | wbits;
        end
    end

    assign irq = |(pend & irq_en);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (ofs)
            GPIO_OUT_OFS:  rd_val[WIDTH-1:0] = out_q;
            GPIO_OE_OFS:   rd_val[WIDTH-1:0] = oe_q;
            GPIO_IN_OFS:   rd_val[WIDTH-1:0] = sync_q;
`ifdef GPIO_IRQ_EN
            GPIO_EN_OFS:   rd_val[WIDTH-1:0] = irq_en;
            GPIO_PEND_OFS: rd_val[WIDTH-1:0] = pend;
            GPIO_POL_OFS:  rd_val[WIDTH-1:0] = pol;
`endif
            default: ;
        endcase
    end

    // rdata is forced to zero outside the ready pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= accept;
            rdata <= accept ? rd_val : '0;
        end
    end

endmodule

// File: doc/mmio_gpio.md
# mmio_gpio

Parametrised memory-mapped GPIO peripheral for the KianV SoC. It supersedes the single write-only LED register with a configurable-width port that has output set/clear/toggle, per-pin output enable, synchronised inputs and optional edge-capture interrupts. It attaches to the CPU `mem_*` bus beside the UART and CLINT and drives the board LEDs and pins.

## Interface
- `BASE_ADDR`, 32'h1200_0000: base of the 64-byte register window. Word offset 0 keeps the legacy LED address.
- `WIDTH`, 8: pin count, legal range 1..32.
- `OUT_RESET`, 8'hF0: reset value of OUT, zero-extended to WIDTH.
- `SYNC_STAGES`, 2: input synchroniser depth, minimum 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `valid`  in  1  CPU request valid (`cpu_mem_valid`).
- `addr`  in  32  byte address.
- `wstrb`  in  4  byte write strobes. Nonzero means write.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data. Nonzero only while `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `is_valid`  out  1  combinational: `valid` and `addr` in [BASE_ADDR, BASE_ADDR+64).
- `gpio_in`  in  WIDTH  asynchronous pin inputs.
- `gpio_out`  out  WIDTH  OUT register.
- `gpio_oe`  out  WIDTH  OE register.
- `irq`  out  1  interrupt request.

## Operation
- Access is accepted when `is_valid` and `ready`=0. On acceptance, `ready` is registered high for exactly one cycle, matching the SoC's `x_ready <= x_valid` pattern.
- Register map (word offsets, byte lanes honoured on writes, bits above WIDTH read 0):
  - 0x00 OUT, rw.
  - 0x04 SET, write-1-set OUT.
  - 0x08 CLR, write-1-clear OUT.
  - 0x0C TGL, write-1-toggle OUT.
  - 0x10 OE, rw, reset 0.
  - 0x14 IN, ro, synchronised.
  - 0x18 IRQ_EN, rw.
  - 0x1C IRQ_PEND, write-1-clear.
  - 0x20 IRQ_POL, rw. 0 selects rising edge, 1 selects falling.
- SET/CLR/TGL read as 0.
- Writes to IN, and reads or writes at offsets 0x24..0x3C, complete normally. Writes have no effect; reads return 0.
- Input path: `gpio_in` feeds a SYNC_STAGES flop chain, then a `prev` register. Edge for pin i is `sync[i] != prev[i]` qualified by IRQ_POL[i].
- An edge on pin i sets PEND[i]. `irq = |(PEND & IRQ_EN)` from registered state, with no extra flop.
- Simultaneous edge and W1C on the same pin: set wins, and PEND stays 1.
- A write to OUT combined with SET/CLR is not possible, because each access targets one offset.

## Timing
- Reset values, all applied asynchronously:
  - `ready`=0, `rdata`=0.
  - OUT=OUT_RESET, so `gpio_out`=OUT_RESET.
  - OE=0, so `gpio_oe`=0.
  - IRQ_EN=0, PEND=0, POL=0, `irq`=0.
  - Synchroniser and `prev` cleared.
- Access latency: exactly one cycle from acceptance to `ready`. Write effects are visible on `gpio_out`/`gpio_oe` in the same cycle `ready` is high.
- Back-to-back accesses: because of the `!ready` gate, one access completes every 2 cycles minimum.
- Input latency: a pin change sampled at edge k is readable in IN after edge k+SYNC_STAGES-1. PEND and `irq` rise after edge k+SYNC_STAGES.
- Reset asserted mid-access: `ready` is dropped immediately and the write is lost. The CPU is reset together with this block, so no completion is owed.

## Configuration
- `GPIO_IRQ_EN` defined: edge detection, IRQ_EN, IRQ_PEND, IRQ_POL and `irq` are implemented as above.
- `GPIO_IRQ_EN` undefined:
  - The `prev` register and the IRQ registers are not built.
  - Offsets 0x18–0x20 read 0 and ignore writes.
  - `irq` is tied to 0.
  - IN and all output features are unchanged.

## Structure
- Shared package `soc_gpio_pkg` holds:
  - the register offset localparams (`GPIO_OUT_OFS` .. `GPIO_POL_OFS`);
  - the window size (64);
  - the legacy LED address constant.
- Sub-module `gpio_sync` is parametrised by WIDTH and SYNC_STAGES. It provides the synchroniser chain plus `prev` register, and outputs `sync_q` and per-bit `rise`/`fall` (edge outputs only under `GPIO_IRQ_EN`).
- Top-level `mmio_gpio` contains the decode, register file and read mux.

## Test plan
- Reset check: after reset, `gpio_out`=8'hF0, `gpio_oe`=0, `irq`=0. Read OUT returns 32'h0000_00F0 with `ready` exactly one cycle after acceptance.
- Write 0x00 with wdata 32'hA5 and wstrb 4'b0001 -> `gpio_out`=8'hA5. Repeat with wstrb 4'b0010 -> OUT unchanged.
- Starting from OUT=8'hA5:
  - write SET 8'h0A -> 8'hAF;
  - write CLR 8'h81 -> 8'h2E;
  - write TGL 8'hFF -> 8'hD1.
  - SET/CLR/TGL all read 0.
- IRQ_EN=8'h01 and POL=0, then drive `gpio_in[0]` 0->1 -> IN[0]=1 after 2 cycles, PEND=8'h01 and `irq`=1 after 3 cycles. Write PEND 8'h01 -> `irq`=0. Repeat with POL[0]=1: only the 1->0 transition sets PEND.
- Edge arriving in the same cycle as a W1C of PEND[0] -> PEND[0] remains 1.
- Address outside window (0x1200_0040) -> `is_valid`=0 and `ready` never asserts. Read offset 0x30 -> rdata 0 and `ready` pulses. Build without `GPIO_IRQ_EN` -> offset 0x18 reads 0 and `irq` stays 0 under pin toggling.
